bit_comparator: RTL and testbench

BIT_COMPARATOR -- requirements
Module: bit_comparator

---
 rtl/bit_comparator.sv | 58 +++++
 tb/tb_bit_comparator.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bit_comparator.sv
// Registered single-bit magnitude comparator with a saturating mismatch counter.
// x and y are sampled on every rising edge outside reset. z, gt, lt and valid
// come straight from flops, so no input reaches an output combinationally.
module bit_comparator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             y,
  output logic             z,
  output logic             gt,
  output logic             lt,
  output logic             valid,
  output logic [CNT_W-1:0] mism_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             z_reg, gt_reg, lt_reg, valid_reg;
  logic             z_next, gt_next, lt_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Decode the current sample and the saturating counter update
  always_comb begin
    z_next   = (x == y);
    gt_next  = x & ~y;
    lt_next  = ~x & y;
    cnt_next = cnt_reg;
    if ((x != y) && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Capture flags and count; reset wins over sampling on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      z_reg     <= 1'b0;
      gt_reg    <= 1'b0;
      lt_reg    <= 1'b0;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      z_reg     <= z_next;
      gt_reg    <= gt_next;
      lt_reg    <= lt_next;
      valid_reg <= 1'b1;
      cnt_reg   <= cnt_next;
    end
  end

  assign z        = z_reg;
  assign gt       = gt_reg;
  assign lt       = lt_reg;
  assign valid    = valid_reg;
  assign mism_cnt = cnt_reg;

endmodule

// File: tb/tb_bit_comparator.sv
// Scoreboard bench: two comparators (default 8-bit counter and a 2-bit counter)
// share the same stimulus. Each issued cycle pushes hand-computed expected
// outputs; a monitor pops one entry per cycle and compares on the falling edge.
module tb_bit_comparator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x = 1'b0;
  logic       y = 1'b0;
  logic       z8, gt8, lt8, valid8;
  logic [7:0] cnt8;
  logic       z2, gt2, lt2, valid2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       z;
    logic       gt;
    logic       lt;
    logic       valid;
    logic [7:0] c8;
    logic [1:0] c2;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  bit_comparator dut8 (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .z(z8), .gt(gt8), .lt(lt8), .valid(valid8), .mism_cnt(cnt8)
  );

  bit_comparator #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .z(z2), .gt(gt2), .lt(lt2), .valid(valid2), .mism_cnt(cnt2)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Issue one cycle: drive inputs after the falling edge, queue the result
  // expected after the following rising edge. glitch pulses x high and back
  // low between edges.
  task automatic step(input string tag, input logic r, input logic xi, input logic yi,
                      input logic ez, input logic egt, input logic elt, input logic ev,
                      input int ec8, input int ec2, input bit glitch = 1'b0);
    exp_t e;
    @(negedge clk);
    #1;
    rst = r;
    x   = xi;
    y   = yi;
    e.z = ez; e.gt = egt; e.lt = elt; e.valid = ev;
    e.c8 = 8'(ec8); e.c2 = 2'(ec2); e.tag = tag;
    exp_q.push_back(e);
    if (glitch) begin
      #1 x = 1'b1;
      #1 x = 1'b0;
    end
  endtask

  // Monitor: compare both DUTs against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, " z"},       int'(z8),     int'(e.z));
        chk({e.tag, " gt"},      int'(gt8),    int'(e.gt));
        chk({e.tag, " lt"},      int'(lt8),    int'(e.lt));
        chk({e.tag, " valid"},   int'(valid8), int'(e.valid));
        chk({e.tag, " cnt8"},    int'(cnt8),   int'(e.c8));
        chk({e.tag, " z w2"},    int'(z2),     int'(e.z));
        chk({e.tag, " gt w2"},   int'(gt2),    int'(e.gt));
        chk({e.tag, " lt w2"},   int'(lt2),    int'(e.lt));
        chk({e.tag, " valid w2"},int'(valid2), int'(e.valid));
        chk({e.tag, " cnt2"},    int'(cnt2),   int'(e.c2));
        $display("cycle %-10s x=%0d y=%0d z=%0d gt=%0d lt=%0d valid=%0d cnt8=%0d cnt2=%0d",
                 e.tag, x, y, z8, gt8, lt8, valid8, cnt8, cnt2);
      end
    end
  end

  // Directed stimulus
  initial begin
    int k;
    //    tag        rst x  y   z  gt lt v  c8 c2
    step("rst0",     1, 0, 0,   0, 0, 0, 0, 0, 0);
    step("rst1",     1, 0, 0,   0, 0, 0, 0, 0, 0);
    step("seq00",    0, 0, 0,   1, 0, 0, 1, 0, 0);
    step("seq10",    0, 1, 0,   0, 1, 0, 1, 1, 1);
    step("seq11a",   0, 1, 1,   1, 0, 0, 1, 1, 1);
    step("seq11b",   0, 1, 1,   1, 0, 0, 1, 1, 1);
    step("seq01",    0, 0, 1,   0, 0, 1, 1, 2, 2);
    step("steady00", 0, 0, 0,   1, 0, 0, 1, 2, 2);
    step("glitch",   0, 0, 0,   1, 0, 0, 1, 2, 2, 1'b1);
    step("glitch2",  0, 0, 0,   1, 0, 0, 1, 2, 2, 1'b1);
    step("rstmid",   1, 1, 0,   0, 0, 0, 0, 0, 0);
    step("hold1",    0, 1, 0,   0, 1, 0, 1, 1, 1);
    step("hold2",    0, 1, 0,   0, 1, 0, 1, 2, 2);
    step("hold3",    0, 1, 0,   0, 1, 0, 1, 3, 3);
    step("hold4",    0, 1, 0,   0, 1, 0, 1, 4, 3);
    step("hold5",    0, 1, 0,   0, 1, 0, 1, 5, 3);
    step("hold6",    0, 1, 0,   0, 1, 0, 1, 6, 3);
    step("rstsat",   1, 1, 0,   0, 0, 0, 0, 0, 0);
    step("restart",  0, 1, 0,   0, 1, 0, 1, 1, 1);
    step("after01",  0, 0, 1,   0, 0, 1, 1, 2, 2);
    // Long mismatch run: 8-bit counter climbs from 2 and pins at 255
    for (k = 1; k <= 260; k++) begin
      step("sat8", 0, 1, 0,   0, 1, 0, 1, (2 + k > 255) ? 255 : 2 + k, 3);
    end
    step("satz",     0, 1, 1,   1, 0, 0, 1, 255, 3);
    step("satrst",   1, 0, 1,   0, 0, 0, 0, 0, 0);
    step("final",    0, 0, 1,   0, 0, 1, 1, 1, 1);

    // Let the monitor drain, bounded
    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
